mbist_ctrl: RTL and testbench
=============================

# mbist_ctrl

March C- sequencer for the memory BIST datapath. It drives address, write data, write enable and read enable to the RAM under test. During reads it presents the expected value on `data_t` to the `comparator`, then samples the comparator's `eq` result one cycle later. It reports pass/fail plus the first failing address and March element, and stops on the first mismatch.

## Interface
Parameters:
- `ADDR_W`, 4: RAM address width; test depth N = 2^ADDR_W.
- `DATA_W`, 8: RAM and comparator data width; background patterns are all-0s and all-1s.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a test run; sampled only in IDLE or DONE.
- `cmp_eq`  in  1  `eq` output of `comparator` (data_t == ramout).
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_din`  out  DATA_W  RAM write data.
- `ram_we`  out  1  RAM write strobe.
- `ram_re`  out  1  RAM read strobe; `ramout` is valid the cycle after.
- `data_t`  out  DATA_W  expected read data to the comparator.
- `busy`  out  1  test in progress.
- `done`  out  1  test finished (level).
- `fail`  out  1  mismatch detected in the last run (level).
- `fail_addr`  out  ADDR_W  address of the first mismatch.
- `fail_elem`  out  3  March element index (0-5) of the first mismatch.

## Operation
- March C- elements. B = all-0s, ~B = all-1s.
  - M0 up: w B.
  - M1 up: r B, w ~B.
  - M2 up: r ~B, w B.
  - M3 down: r B, w ~B.
  - M4 down: r ~B, w B.
  - M5 down: r B.
- Up elements run address 0 to N-1; down elements run N-1 to 0.
- States:
  - IDLE: all strobes low. `start` goes to RUN with element 0 at address 0.
  - RUN: executes the elements. The per-address op sub-state is WR, RD or CMP.
  - DONE: `done`=1. `start` clears `done`, `fail`, `fail_addr` and `fail_elem`, then enters RUN.
- Per-address cycles:
  - Write-only element (M0): one WR cycle. `ram_we`=1, `ram_din`=pattern.
  - Read element, RD cycle: `ram_re`=1, `ram_addr`=current address, `data_t`=expected pattern.
  - Read element, CMP cycle: `data_t` holds the expected pattern and `cmp_eq` is sampled.
    - If the element writes, the CMP cycle also drives `ram_we`=1 at the same address with the new pattern.
    - M5's CMP cycle has no write.
- Mismatch: `cmp_eq`=0 in a CMP cycle.
  - `fail`, `fail_addr`, `fail_elem` are registered.
  - The write in that CMP cycle is suppressed (`ram_we`=0).
  - Next state is DONE.
- Completion: after the CMP cycle of M5 at address 0, go to DONE with `fail`=0.
- Address counter runs modulo N. The element advances when the counter reaches its terminal value: N-1 for up, 0 for down. The counter is then loaded with 0 (up) or N-1 (down).
- `start` while in RUN is ignored.

## Timing
- Reset values:
  - `busy`, `done`, `fail`, `ram_we`, `ram_re` = 0.
  - `ram_addr`, `ram_din`, `data_t`, `fail_addr`, `fail_elem` = 0.
  - State = IDLE.
- Reset asserted mid-run aborts immediately to IDLE and drops all strobes asynchronously.
- `busy` rises in the cycle after `start` is sampled. The first WR (address 0) is in that same cycle.
- All outputs are registered; strobes, address and data change together on the rising edge.
- Fault-free run length is 11·N busy cycles:
  - M0: N cycles.
  - M1-M4: 2N cycles each.
  - M5: 2N cycles.
- In the cycle after the final CMP:
  - `busy`=0 and `done`=1.
- On a mismatch detected in a CMP cycle, in the next cycle:
  - `busy`=0, `done`=1, `fail`=1.
- `cmp_eq` is ignored outside CMP cycles.
- `done`/`fail` hold until the next accepted `start` or reset.

## Test plan
- ADDR_W=2, fault-free 4×8 RAM model, pulse `start` -> `busy` high exactly 44 cycles, then `done`=1, `fail`=0; write/read address order matches March C- (0..3, then 3..0 from M3).
- Bit 3 of address 2 stuck-at-0 -> first mismatch in M2 (r ~B reads 8'hF7) -> `fail`=1, `fail_addr`=2, `fail_elem`=2; no `ram_we` in the failing CMP cycle; `busy` drops after 4+8+4+2 = 18 busy cycles.
- Bit 0 of address 3 stuck-at-1 -> mismatch in M1 at address 3 (reads 8'h01) -> `fail_addr`=3, `fail_elem`=1.
- Assert `rst` during M3 -> outputs return to reset values immediately. A following `start` reruns from M0 address 0 and passes on a good RAM.
- `start` pulsed during RUN -> ignored, total still 44 cycles. `start` in DONE after a failing run -> `fail` cleared and a new run begins.
- `start` and `rst` both high -> stays IDLE, `busy`=0. `start` on the first cycle after `rst` deasserts -> run starts normally.

Source files
------------

// File: rtl/mbist_ctrl.sv
// mbist_ctrl: March C- sequencer for the memory BIST datapath.
// Walks M0..M5 over the RAM under test, presents the expected read value
// on data_t, samples the comparator result in the cycle after each read,
// and stops on the first mismatch.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         begin a run (honoured in IDLE or DONE only)
//   cmp_eq        comparator equality result (data_t == ramout)
//   ram_addr/ram_din/ram_we/ram_re  RAM control
//   data_t        expected read data to the comparator
//   busy/done/fail                  run status
//   fail_addr/fail_elem             first failing address / March element
module mbist_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmp_eq,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              ram_re,
  output logic [DATA_W-1:0] data_t,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  localparam logic [ADDR_W-1:0] LP_ADDR_LAST = '1;
  localparam logic [2:0]        LP_ELEM_LAST = 3'd5;
  localparam logic [2:0]        LP_ELEM_DOWN = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {OP_WR, OP_RD, OP_CMP} op_t;

  state_t            r_state, w_state;
  op_t               r_op, w_op;
  logic [2:0]        r_elem, w_elem, w_elem_inc;
  logic [ADDR_W-1:0] r_ram_addr, w_addr;
  logic [DATA_W-1:0] r_ram_din, w_din, r_data_t, w_data_t;
  logic              r_ram_we, w_we, r_ram_re, w_re;
  logic              r_busy, w_busy, r_done, w_done;
  logic              r_fail, w_fail;
  logic [ADDR_W-1:0] r_fail_addr, w_fail_addr;
  logic [2:0]        r_fail_elem, w_fail_elem;
  logic              w_down, w_term;

  // March C- element table: read background, write background, write present
  function automatic logic f_rd_ones(input logic [2:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  function automatic logic f_wr_ones(input logic [2:0] e);
    return (e == 3'd1) || (e == 3'd3);
  endfunction

  function automatic logic [DATA_W-1:0] f_pat(input logic ones);
    return ones ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  endfunction

  // Next-state and next-output logic
  always_comb begin
    w_state     = r_state;
    w_op        = r_op;
    w_elem      = r_elem;
    w_addr      = r_ram_addr;
    w_fail      = r_fail;
    w_fail_addr = r_fail_addr;
    w_fail_elem = r_fail_elem;
    w_elem_inc  = r_elem + 3'd1;
    w_down      = (r_elem >= LP_ELEM_DOWN);
    w_term      = w_down ? (r_ram_addr == '0) : (r_ram_addr == LP_ADDR_LAST);

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state     = S_RUN;
          w_op        = OP_WR;
          w_elem      = '0;
          w_addr      = '0;
          w_fail      = 1'b0;
          w_fail_addr = '0;
          w_fail_elem = '0;
        end
      end
      S_RUN: begin
        case (r_op)
          OP_WR: begin
            // Only M0 uses WR; it is followed by M1 (up, from address 0)
            if (w_term) begin
              w_elem = 3'd1;
              w_addr = '0;
              w_op   = OP_RD;
            end else begin
              w_addr = r_ram_addr + ADDR_W'(1);
            end
          end
          OP_RD: w_op = OP_CMP;
          OP_CMP: begin
            if (!cmp_eq) begin
              w_fail      = 1'b1;
              w_fail_addr = r_ram_addr;
              w_fail_elem = r_elem;
              w_state     = S_DONE;
            end else if (w_term) begin
              if (r_elem == LP_ELEM_LAST) begin
                w_state = S_DONE;
              end else begin
                w_elem = w_elem_inc;
                w_addr = (w_elem_inc >= LP_ELEM_DOWN) ? LP_ADDR_LAST : '0;
                w_op   = OP_RD;
              end
            end else begin
              w_addr = w_down ? (r_ram_addr - ADDR_W'(1)) : (r_ram_addr + ADDR_W'(1));
              w_op   = OP_RD;
            end
          end
          default: w_state = S_IDLE;
        endcase
      end
      default: w_state = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it
    w_busy   = (w_state == S_RUN);
    w_done   = (w_state == S_DONE);
    w_we     = 1'b0;
    w_re     = 1'b0;
    w_din    = r_ram_din;
    w_data_t = r_data_t;
    if (w_state == S_RUN) begin
      case (w_op)
        OP_WR: begin
          w_we  = 1'b1;
          w_din = f_pat(f_wr_ones(w_elem));
        end
        OP_RD: begin
          w_re     = 1'b1;
          w_data_t = f_pat(f_rd_ones(w_elem));
        end
        OP_CMP: begin
          w_we     = (w_elem != LP_ELEM_LAST);
          w_din    = f_pat(f_wr_ones(w_elem));
          w_data_t = f_pat(f_rd_ones(w_elem));
        end
        default: ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_WR;
      r_elem      <= '0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_ram_we    <= 1'b0;
      r_ram_re    <= 1'b0;
      r_data_t    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
    end else begin
      r_state     <= w_state;
      r_op        <= w_op;
      r_elem      <= w_elem;
      r_ram_addr  <= w_addr;
      r_ram_din   <= w_din;
      r_ram_we    <= w_we;
      r_ram_re    <= w_re;
      r_data_t    <= w_data_t;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_fail      <= w_fail;
      r_fail_addr <= w_fail_addr;
      r_fail_elem <= w_fail_elem;
    end
  end

  // The comparator result only exists during the CMP cycle itself, so the
  // read-modify write of a failing location is cancelled by gating the
  // registered strobe with cmp_eq.
  assign ram_we    = r_ram_we & (cmp_eq | (r_op != OP_CMP));
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign ram_re    = r_ram_re;
  assign data_t    = r_data_t;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_elem = r_fail_elem;

endmodule

// File: tb/tb_mbist_ctrl.sv
// Scoreboard bench for mbist_ctrl with a faulty-RAM environment model.
module tb_mbist_ctrl;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, start, cmp_eq;
  logic [AW-1:0] ram_addr, fail_addr;
  logic [DW-1:0] ram_din, data_t;
  logic          ram_we, ram_re, busy, done, fail;
  logic [2:0]    fail_elem;

  mbist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .cmp_eq(cmp_eq),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_re(ram_re),
    .data_t(data_t), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem)
  );

  always #5 clk = ~clk;

  // RAM under test with per-address stuck-at masks, synchronous read
  logic [DW-1:0] mem [N];
  logic [DW-1:0] sa0 [N];
  logic [DW-1:0] sa1 [N];
  logic [DW-1:0] ramout = '0;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_re) ramout <= (mem[ram_addr] & ~sa0[ram_addr]) | sa1[ram_addr];
  end
  assign cmp_eq = (data_t == ramout);

  typedef struct {
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dt;
    logic          chk_dt;
  } cyc_t;

  typedef struct {
    logic          fail;
    logic [AW-1:0] addr;
    logic [2:0]    elem;
    int            cycles;
  } res_t;

  cyc_t tq[$];
  res_t rq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic logic [DW-1:0] pat(input int ones);
    return (ones != 0) ? {DW{1'b1}} : {DW{1'b0}};
  endfunction

  // Reference: March C- as a table (-1 = no op), applied to an abstract
  // memory with the same stuck-at masks; emits the expected cycle trace.
  task automatic model_run();
    int rd_bg [6] = '{-1, 0, 1, 0, 1, 0};
    int wr_bg [6] = '{0, 1, 0, 1, 0, -1};
    logic [DW-1:0] m [N];
    logic [DW-1:0] v, exp;
    cyc_t c;
    res_t r;
    int a;
    r.fail = 1'b0; r.addr = '0; r.elem = '0; r.cycles = 0;
    for (int i = 0; i < int'(N); i++) m[i] = DW'($urandom);
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < int'(N); k++) begin
        a = (e < 3) ? k : int'(N) - 1 - k;
        c.addr = AW'(a);
        if (rd_bg[e] < 0) begin
          c.we = 1'b1; c.re = 1'b0; c.din = pat(wr_bg[e]); c.dt = '0; c.chk_dt = 1'b0;
          tq.push_back(c);
          m[a] = pat(wr_bg[e]);
          r.cycles++;
        end else begin
          exp = pat(rd_bg[e]);
          c.we = 1'b0; c.re = 1'b1; c.din = '0; c.dt = exp; c.chk_dt = 1'b1;
          tq.push_back(c);
          v = (m[a] & ~sa0[a]) | sa1[a];
          c.re = 1'b0;
          c.we = (v == exp) && (wr_bg[e] >= 0);
          c.din = (wr_bg[e] >= 0) ? pat(wr_bg[e]) : '0;
          tq.push_back(c);
          r.cycles += 2;
          if (v != exp) begin
            r.fail = 1'b1; r.addr = AW'(a); r.elem = 3'(e);
            rq.push_back(r);
            return;
          end
          if (wr_bg[e] >= 0) m[a] = pat(wr_bg[e]);
        end
      end
    end
    rq.push_back(r);
  endtask

  // Monitor: compares each busy cycle and each completed run
  initial begin : monitor
    logic prev_done;
    int   bcount;
    cyc_t c;
    res_t r;
    prev_done = 1'b0;
    bcount = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
        bcount = 0;
      end else begin
        if (busy) begin
          bcount++;
          if (tq.size() == 0) fail_now("unexpected_busy_cycle");
          else begin
            c = tq.pop_front();
            chk("cyc_we_re_addr", {ram_we, ram_re, 30'(ram_addr)}, {c.we, c.re, 30'(c.addr)});
            if (c.we) chk("cyc_din", ram_din, c.din);
            if (c.chk_dt) chk("cyc_data_t", data_t, c.dt);
          end
        end
        if (done && !prev_done) begin
          if (rq.size() == 0) fail_now("unexpected_done");
          else begin
            r = rq.pop_front();
            chk("res_fail", fail, r.fail);
            if (r.fail) begin
              chk("res_fail_addr", fail_addr, r.addr);
              chk("res_fail_elem", fail_elem, r.elem);
            end
            chk("res_busy_cycles", bcount, r.cycles);
            chk("res_trace_left", tq.size(), 0);
          end
          bcount = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < int'(N); i++) begin
      sa0[i] = '0;
      sa1[i] = '0;
    end
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (done && !busy) break;
      tick();
    end
    if (i == budget) fail_now("wait_done_timeout");
    @(negedge clk);
    tick();
  endtask

  // pulse_at > 0 pulses start that many cycles into the run (ignored in RUN)
  task automatic do_run(input int pulse_at);
    model_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_busy_after_start", busy, 1'b1);
    chk("run_done_cleared", done, 1'b0);
    chk("run_fail_cleared", {fail, 30'(fail_addr), fail_elem}, '0);
    if (pulse_at > 0) begin
      for (int i = 0; i < pulse_at; i++) tick();
      if (busy) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    wait_done(200);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_status"}, {busy, done, fail, ram_we, ram_re}, '0);
    chk({nm, "_addr_data"}, {ram_addr, ram_din, data_t}, '0);
    chk({nm, "_fail_info"}, {fail_addr, fail_elem}, '0);
  endtask

  initial begin : stim
    logic [DW-1:0] mk;
    int fa;
    rst = 1'b1;
    start = 1'b0;
    clear_faults();
    for (int i = 0; i < int'(N); i++) mem[i] = '0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Fault-free run, then the two directed stuck-at faults
    do_run(0);
    sa0[2] = 8'h08;
    do_run(0);
    clear_faults();
    sa1[3] = 8'h01;
    do_run(0);
    clear_faults();

    // Start in DONE after a failing run, plus an ignored start in RUN
    do_run(17);

    // Reset in M3 aborts; rerun passes
    model_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (22) tick();
    rst = 1'b1;
    #1;
    check_reset_vals("abort");
    tq.delete();
    rq.delete();
    tick();
    rst = 1'b0;
    tick();
    do_run(0);

    // start held during reset: stays idle, then starts on release
    rst = 1'b1;
    start = 1'b1;
    repeat (3) tick();
    chk("rst_start_idle", {busy, done}, 2'b00);
    model_run();
    rst = 1'b0;
    tick();
    start = 1'b0;
    chk("start_after_rst", busy, 1'b1);
    wait_done(200);

    // Randomised faults, pulses and idle gaps
    for (int it = 0; it < 12; it++) begin
      clear_faults();
      fa = $urandom_range(0, N - 1);
      mk = DW'(1) << $urandom_range(0, DW - 1);
      case ($urandom_range(0, 2))
        0: sa0[fa] = mk;
        1: sa1[fa] = mk;
        default: ;
      endcase
      repeat ($urandom_range(0, 3)) tick();
      do_run(($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 40)) : 0);
    end

    repeat (2) tick();
    chk("final_trace_empty", tq.size(), 0);
    chk("final_result_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
